// File: rtl/axi_lite_rd_arbiter_if.sv
// axi_lite_rd_arbiter_if: request/response ports of both requesters plus the shared AXI-lite read port
// slave  : arbiter side (takes requests and memory returns, drives readies, responses and the memory address)
// master : environment side (requesters and memory)
interface axi_lite_rd_arbiter_if;
  logic        i_req_valid;
  logic [31:0] i_req_addr;
  logic        i_req_ready;
  logic        i_rsp_valid;
  logic [63:0] i_rsp_data;
  logic [1:0]  i_rsp_resp;
  logic        d_req_valid;
  logic [31:0] d_req_addr;
  logic        d_req_ready;
  logic        d_rsp_valid;
  logic [63:0] d_rsp_data;
  logic [1:0]  d_rsp_resp;
  logic        m_arvalid;
  logic [31:0] m_araddr;
  logic        m_arready;
  logic [63:0] m_rdata;
  logic        m_rvalid;
  logic [1:0]  m_rresp;
  modport slave (
    input  i_req_valid, i_req_addr, d_req_valid, d_req_addr, m_arready, m_rdata, m_rvalid, m_rresp,
    output i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_resp,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_resp,
    output m_arvalid, m_araddr
  );
  modport master (
    output i_req_valid, i_req_addr, d_req_valid, d_req_addr, m_arready, m_rdata, m_rvalid, m_rresp,
    input  i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_resp,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_resp,
    input  m_arvalid, m_araddr
  );
endinterface

// File: rtl/axi_lite_rd_arbiter.sv
// axi_lite_rd_arbiter: shares one AXI-lite read port between instruction and data requesters, with watchdog
// clk, rst_n : clock and asynchronous active-low reset
// bus        : axi_lite_rd_arbiter_if.slave (i_/d_ request+response ports, m_ memory read port)
// busy       : high whenever a transaction is in flight
// TIMEOUT    : cycles from address issue to forced SLVERR response (2..255)
// ARB_RR_EN  : when defined, ties are broken round-robin; otherwise the data port always wins
module axi_lite_rd_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  axi_lite_rd_arbiter_if.slave        bus,
  output logic                        busy
);
  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;
  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);
  state_t state, state_nxt;
  logic [31:0] addr;
  logic [7:0] cnt;
  logic owner_d, grant_d, grant_i, accept, got_r, expire, done;
`ifdef ARB_RR_EN
  // Reset value means "instruction granted last", so the data port wins the first tie.
  logic last_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_d <= 1'b0;
    else if (accept) last_d <= grant_d;
  assign grant_d = bus.d_req_valid & (~bus.i_req_valid | ~last_d);
`else
  assign grant_d = bus.d_req_valid;
`endif
  assign grant_i = bus.i_req_valid & ~grant_d;
  assign accept = state == IDLE && (grant_i || grant_d);
  // A real read return beats the watchdog when both land on the same cycle.
  assign got_r = state == RESP && bus.m_rvalid;
  assign expire = state != IDLE && cnt == LIMIT;
  assign done = got_r | expire;
  assign bus.m_araddr = addr;
  always_comb begin
    state_nxt = state;
    bus.i_req_ready = state == IDLE && grant_i;
    bus.d_req_ready = state == IDLE && grant_d;
    bus.m_arvalid = state == ADDR;
    busy = state != IDLE;
    if (accept) state_nxt = ADDR;
    else if (done) state_nxt = IDLE;
    else if (state == ADDR && bus.m_arready) state_nxt = RESP;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr <= '0;
      owner_d <= 1'b0;
      cnt <= '0;
      bus.i_rsp_valid <= 1'b0;
      bus.i_rsp_data <= '0;
      bus.i_rsp_resp <= '0;
      bus.d_rsp_valid <= 1'b0;
      bus.d_rsp_data <= '0;
      bus.d_rsp_resp <= '0;
    end else begin
      if (accept) begin
        addr <= grant_d ? bus.d_req_addr : bus.i_req_addr;
        owner_d <= grant_d;
        cnt <= '0;
      end else if (state != IDLE) cnt <= cnt + 8'd1;
      bus.i_rsp_valid <= done & ~owner_d;
      bus.d_rsp_valid <= done & owner_d;
      if (done & ~owner_d) begin
        bus.i_rsp_data <= got_r ? bus.m_rdata : '0;
        bus.i_rsp_resp <= got_r ? bus.m_rresp : 2'b10;
      end
      if (done & owner_d) begin
        bus.d_rsp_data <= got_r ? bus.m_rdata : '0;
        bus.d_rsp_resp <= got_r ? bus.m_rresp : 2'b10;
      end
    end
endmodule

// File: doc/axi_lite_rd_arbiter.md
# axi_lite_rd_arbiter

Two-requester read arbiter that shares the single AXI-lite read memory port between the core's instruction-fetch and data-load paths. It accepts one request at a time, drives the memory address channel, captures the 64-bit read response and returns it to the owning requester as a one-cycle pulse. A watchdog counter converts a hung memory transaction into an error response.

## Interface
- TIMEOUT, 64: cycles allowed from address issue to `m_rvalid` before an error response is forced; legal range 2..255.
- CLK  in  1  clock; all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- i_req_valid  in  1  instruction port request.
- i_req_addr  in  32  instruction read byte address.
- i_req_ready  out  1  instruction request accepted this cycle.
- i_rsp_valid  out  1  instruction response pulse.
- i_rsp_data  out  64  instruction response data.
- i_rsp_resp  out  2  instruction response code.
- d_req_valid, d_req_addr, d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_resp: data port, same directions, widths and meaning as the `i_` port.
- m_arvalid  out  1  memory address valid.
- m_araddr  out  32  memory address.
- m_arready  in  1  memory address ready.
- m_rdata  in  64  memory read data.
- m_rvalid  in  1  memory read valid.
- m_rresp  in  2  memory response code.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE: arbitrate between valid requesters.
    - Winner's `*_req_ready` is asserted combinationally in the same cycle; the loser's is 0.
    - On `valid & ready`: latch the address and the owner, clear the watchdog, move to ADDR.
    - No valid request: stay in IDLE.
  - ADDR: `m_arvalid` = 1, `m_araddr` = latched address.
    - On `m_arready`: move to RESP.
  - RESP: `m_arvalid` = 0.
    - On `m_rvalid`: register `m_rdata` and `m_rresp` to the owner's `*_rsp_data` and `*_rsp_resp`, set the owner's `*_rsp_valid`, move to IDLE.
- Watchdog: 8-bit counter, increments every cycle in ADDR and RESP.
  - When it reaches TIMEOUT-1 without `m_rvalid`, the owner receives data 0 and resp 2'b10 (SLVERR), and the FSM moves to IDLE.
  - If `m_rvalid` arrives in the same cycle the counter reaches TIMEOUT-1, `m_rvalid` wins.
- Response handling:
  - `*_rsp_valid` is high for exactly one cycle. There is no response backpressure.
  - `*_rsp_data` and `*_rsp_resp` hold their value until the next response to that port.
  - The non-owner's `*_rsp_valid` stays 0.
- `m_rresp` is passed through unmodified. `m_rdata` is passed through in full; the lower 32 bits carry the word.
- A requester dropping `*_req_valid` after acceptance has no effect on the in-flight transaction.

## Timing
- Reset (asynchronous assert, synchronous deassert by the clock domain):
  - All outputs are 0, including `m_araddr` and both `*_rsp_data`.
  - FSM goes to IDLE, watchdog to 0, round-robin pointer to "instruction last granted".
- Reset mid-transaction discards the in-flight response; no `*_rsp_valid` is produced for it.
- Latency with `m_arready` = 1 and memory `rvalid` one cycle after `arvalid`:
  - Request accepted at edge E0.
  - `m_arvalid` is high during E0–E1; handshake at E1.
  - Capture at E2; `*_rsp_valid` is high during E2–E3.
- Back-to-back: the cycle in which `*_rsp_valid` is high is an IDLE cycle, so a new request can be accepted at E3.
- Throughput: one transaction per 3 cycles.
- Only one transaction is outstanding at any time.

## Configuration
- ARB_RR_EN defined:
  - Round-robin tie-break. When both ports request, the port not granted last wins.
  - The pointer updates on every acceptance.
  - After reset the data port wins the first tie.
- ARB_RR_EN undefined:
  - Fixed priority: the data port always wins ties.
  - No pointer register is built.

## Test plan
- Single instruction request, addr 0x0000_0010, memory word 0x0000_0013 -> `i_rsp_valid` for one cycle 2 edges after acceptance, `i_rsp_data` 0x0000_0000_0000_0013, `i_rsp_resp` 2'b00; `d_rsp_valid` stays 0.
- Both ports request every cycle for 4 transactions:
  - without ARB_RR_EN -> grants D,D,D,D;
  - with ARB_RR_EN -> D,I,D,I.
  - Each response returns to the correct port.
- `m_arready` held 0 for 5 cycles -> `m_arvalid` and `m_araddr` stable throughout; the response arrives normally after `m_arready` rises.
- TIMEOUT=8, `m_rvalid` never asserted -> owner `*_rsp_valid` at the 8th cycle after issue, data 0, resp 2'b10, `busy` returns to 0.
- `RST_N` pulsed low while in RESP -> all outputs 0 immediately, no response pulse; the next request completes normally.
- Memory returns `m_rresp` 2'b10 with data 0xDEAD -> owner receives resp 2'b10 and data 0x0000_0000_0000_DEAD unchanged.
